ddr_rd_engine: RTL

//  AXI4 read master between the ctrl sequencer and the DDR interconnect. Takes one-burst read commands
//  (RSTART_REG / RADDR_REG / RLENGTH_REG), issues one INCR burst on AR and collects the R beats.

---
 rtl/ddr_rd_engine.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ddr_rd_engine.sv
// rtl/ddr_rd_engine.sv - AXI4 single-burst read master with AXI-Stream beat output
//
// Accepts one-burst read commands, issues one INCR burst on AR, forwards the R beats
// through a one-entry output register onto an AXI-Stream port, and keeps sticky
// error flags plus bandwidth counters.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   RSTART_REG/RADDR_REG/RLENGTH_REG  command pulse, byte address, beat count ([4:0] used)
//   RIDLE_REG                      1 = idle and ready for a command
//   m_axi_ar*                      AR channel (arsize/arburst constant)
//   m_axi_r*                       R channel
//   m_axis_t*                      output stream, tlast on the final beat of a burst
//   clr_stats                      synchronous clear of err_o and counters
//   err_o                          sticky {len, align, resp, last}
//   beat_cnt_o / busy_cyc_o        accepted R beats / cycles spent not idle
module ddr_rd_engine #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              RSTART_REG,
    input  logic [ADDR_W-1:0] RADDR_REG,
    input  logic [31:0]       RLENGTH_REG,
    output logic              RIDLE_REG,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              clr_stats,
    output logic [3:0]        err_o,
    output logic [31:0]       beat_cnt_o,
    output logic [31:0]       busy_cyc_o
);

    localparam int             BYTES_LOG = $clog2(DATA_W / 8);
    localparam logic [5:0]     MAX_LEN_W = 6'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AR    = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    logic                ridle_q;
    logic [ADDR_W-1:0]   araddr_q;
    logic [7:0]          arlen_q;
    logic                arvalid_q;
    logic [4:0]          len_q;
    logic [4:0]          bcnt_q;
    logic [DATA_W-1:0]   tdata_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic [3:0]          err_q, err_d, err_set;
    logic [31:0]         beat_cnt_q, beat_cnt_d;
    logic [31:0]         busy_cyc_q, busy_cyc_d;

    logic [4:0]          len_w;
    logic                len_bad, align_bad, cross_bad, cmd_ok;
    logic [13:0]         end_off;
    logic                rready;
    logic                r_hs, s_hs;
    logic [4:0]          beat_num;
    logic                is_final;
    logic                unused_bits;

    assign len_w     = RLENGTH_REG[4:0];
    assign len_bad   = (len_w == 5'd0) || ({1'b0, len_w} > MAX_LEN_W);
    assign align_bad = |RADDR_REG[BYTES_LOG-1:0];
    // One past the last byte of the burst within its 4 KB page; beyond 0x1000 means a crossing.
    assign end_off   = {2'b00, RADDR_REG[11:0]} + (14'(len_w) << BYTES_LOG);
    assign cross_bad = end_off > 14'h1000;
    assign cmd_ok    = !(len_bad || align_bad || cross_bad);

    // Accept an R beat whenever the output register is empty or is being drained this cycle.
    assign rready    = (state_q == S_DATA) && (!tvalid_q || m_axis_tready);
    assign r_hs      = m_axi_rvalid && rready;
    assign s_hs      = tvalid_q && m_axis_tready;
    assign beat_num  = bcnt_q + 5'd1;
    assign is_final  = (beat_num == len_q);

    assign unused_bits = ^RLENGTH_REG[31:5];

    always_comb begin
        err_set = 4'b0000;
        if (state_q == S_IDLE && RSTART_REG) begin
            err_set[3] = len_bad;
            err_set[2] = align_bad || cross_bad;
        end
        if (r_hs) begin
            err_set[1] = (m_axi_rresp != 2'b00);
            err_set[0] = (m_axi_rlast != is_final);
        end
        // Clear wins over any same-cycle update.
        err_d      = clr_stats ? 4'b0000 : (err_q | err_set);
        beat_cnt_d = clr_stats ? 32'd0 : (beat_cnt_q + {31'd0, r_hs});
        busy_cyc_d = clr_stats ? 32'd0 : (busy_cyc_q + {31'd0, !ridle_q});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ridle_q    <= 1'b1;
            araddr_q   <= '0;
            arlen_q    <= 8'd0;
            arvalid_q  <= 1'b0;
            len_q      <= 5'd0;
            bcnt_q     <= 5'd0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            err_q      <= 4'b0000;
            beat_cnt_q <= 32'd0;
            busy_cyc_q <= 32'd0;
        end else begin
            err_q      <= err_d;
            beat_cnt_q <= beat_cnt_d;
            busy_cyc_q <= busy_cyc_d;
            unique case (state_q)
                S_IDLE: begin
                    if (RSTART_REG && cmd_ok) begin
                        araddr_q  <= RADDR_REG;
                        arlen_q   <= 8'(len_w) - 8'd1;
                        len_q     <= len_w;
                        bcnt_q    <= 5'd0;
                        arvalid_q <= 1'b1;
                        ridle_q   <= 1'b0;
                        state_q   <= S_AR;
                    end
                end
                S_AR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_hs) begin
                        tdata_q  <= m_axi_rdata;
                        tvalid_q <= 1'b1;
                        tlast_q  <= is_final;
                        bcnt_q   <= beat_num;
                        // The counted final beat ends the burst whatever rlast says.
                        if (is_final) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (s_hs) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (s_hs) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if (tlast_q) begin
                            ridle_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RIDLE_REG     = ridle_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(BYTES_LOG);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign err_o         = err_q;
    assign beat_cnt_o    = beat_cnt_q;
    assign busy_cyc_o    = busy_cyc_q;

endmodule
